// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-sequencing control for the 5-stage core.
// Operand bypass selects, latch enables/clears, debug halt and perf counters.
module hazard_ctrl #(
    parameter int ADDR_W        = 5,
    parameter int ALU_SRC_SEL_W = 2,
    parameter int CNT_W         = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        rf_src0_d,
    input  logic [ADDR_W-1:0]        rf_src1_d,
    input  logic [ADDR_W-1:0]        rf_src0_e,
    input  logic [ADDR_W-1:0]        rf_src1_e,
    input  logic [ADDR_W-1:0]        rf_dst_e,
    input  logic                     mem2rf_e,
    input  logic [ADDR_W-1:0]        rf_waddr_m,
    input  logic                     rf_we_m,
    input  logic                     pc_src_m,
    input  logic                     dmem_req_m,
    input  logic                     dmem_ready,
    input  logic [ADDR_W-1:0]        rf_waddr_w,
    input  logic                     rf_we_w,
    input  logic                     halt_req,
    output logic [ALU_SRC_SEL_W-1:0] alu_src0_sel,
    output logic [ALU_SRC_SEL_W-1:0] alu_src1_sel,
    output logic                     fetch_en,
    output logic                     decode_en,
    output logic                     decode_clr,
    output logic                     execute_en,
    output logic                     execute_clr,
    output logic                     memory_en,
    output logic                     halt_ack,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    localparam logic [ALU_SRC_SEL_W-1:0] SEL_RF = ALU_SRC_SEL_W'(0);
    localparam logic [ALU_SRC_SEL_W-1:0] SEL_WB = ALU_SRC_SEL_W'(1);
    localparam logic [ALU_SRC_SEL_W-1:0] SEL_ME = ALU_SRC_SEL_W'(2);
    localparam logic [ADDR_W-1:0]        X0     = '0;
    localparam logic [CNT_W-1:0]         CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_halt_ack;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_lu;
    logic w_wait;
    logic w_flush;
    logic w_src0_hit_m;
    logic w_src0_hit_w;
    logic w_src1_hit_m;
    logic w_src1_hit_w;

    // ME is the younger producer, so it wins over WB; x0 is hardwired zero.
    assign w_src0_hit_m = rf_we_m && (rf_waddr_m == rf_src0_e) && (rf_src0_e != X0);
    assign w_src0_hit_w = rf_we_w && (rf_waddr_w == rf_src0_e) && (rf_src0_e != X0);
    assign w_src1_hit_m = rf_we_m && (rf_waddr_m == rf_src1_e) && (rf_src1_e != X0);
    assign w_src1_hit_w = rf_we_w && (rf_waddr_w == rf_src1_e) && (rf_src1_e != X0);

    always_comb begin
        alu_src0_sel = SEL_RF;
        if (w_src0_hit_m) begin
            alu_src0_sel = SEL_ME;
        end else if (w_src0_hit_w) begin
            alu_src0_sel = SEL_WB;
        end
    end

    always_comb begin
        alu_src1_sel = SEL_RF;
        if (w_src1_hit_m) begin
            alu_src1_sel = SEL_ME;
        end else if (w_src1_hit_w) begin
            alu_src1_sel = SEL_WB;
        end
    end

    assign w_lu = mem2rf_e && (rf_dst_e != X0) &&
                  ((rf_dst_e == rf_src0_d) || (rf_dst_e == rf_src1_d));

    assign w_wait = dmem_req_m && !dmem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Halt is only taken from RUN; MEM_WAIT always drains back to RUN first.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_RUN: begin
                if (w_wait) begin
                    w_next = S_MEM_WAIT;
                end else if (halt_req && !w_lu) begin
                    w_next = S_HALT;
                end
            end
            S_MEM_WAIT: begin
                if (!w_wait) begin
                    w_next = S_RUN;
                end
            end
            S_HALT: begin
                if (!halt_req) begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_RUN;
        endcase
    end

    // MEM_WAIT shares the RUN decode: it freezes while the access is
    // outstanding and decodes normally in the cycle the memory answers.
    always_comb begin
        fetch_en    = 1'b1;
        decode_en   = 1'b1;
        decode_clr  = 1'b0;
        execute_en  = 1'b1;
        execute_clr = 1'b0;
        memory_en   = 1'b1;
        w_flush     = 1'b0;
        if ((r_state == S_HALT) || w_wait) begin
            fetch_en   = 1'b0;
            decode_en  = 1'b0;
            execute_en = 1'b0;
            memory_en  = 1'b0;
        end else if (pc_src_m) begin
            decode_clr  = 1'b1;
            execute_clr = 1'b1;
            w_flush     = 1'b1;
        end else if (w_lu) begin
            fetch_en   = 1'b0;
            decode_en  = 1'b0;
            decode_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halt_ack <= 1'b0;
        end else begin
            r_halt_ack <= (w_next == S_HALT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!fetch_en && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign halt_ack  = r_halt_ack;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazards plus random traffic
// against a cycle-level reference model; a narrow-counter copy shows saturation.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] rf_src0_d = '0, rf_src1_d = '0;
    logic [4:0] rf_src0_e = '0, rf_src1_e = '0;
    logic [4:0] rf_dst_e = '0, rf_waddr_m = '0, rf_waddr_w = '0;
    logic       mem2rf_e = 0, rf_we_m = 0, pc_src_m = 0;
    logic       dmem_req_m = 0, dmem_ready = 0, rf_we_w = 0, halt_req = 0;

    logic [1:0]  alu_src0_sel, alu_src1_sel;
    logic        fetch_en, decode_en, decode_clr;
    logic        execute_en, execute_clr, memory_en, halt_ack;
    logic [31:0] stall_cnt, flush_cnt;

    logic [1:0]  s_sel0, s_sel1;
    logic        s_fe, s_de, s_dc, s_ee, s_ec, s_me, s_ha;
    logic [3:0]  s_stall, s_flush;

    int n_chk = 0;
    int n_err = 0;

    longint m_stalls;
    longint m_flushes;
    bit     m_halted;
    bit     m_waiting;

    always #5 clk = ~clk;

    hazard_ctrl #(.ADDR_W(5), .ALU_SRC_SEL_W(2), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset),
        .rf_src0_d(rf_src0_d), .rf_src1_d(rf_src1_d),
        .rf_src0_e(rf_src0_e), .rf_src1_e(rf_src1_e),
        .rf_dst_e(rf_dst_e), .mem2rf_e(mem2rf_e),
        .rf_waddr_m(rf_waddr_m), .rf_we_m(rf_we_m),
        .pc_src_m(pc_src_m), .dmem_req_m(dmem_req_m),
        .dmem_ready(dmem_ready), .rf_waddr_w(rf_waddr_w),
        .rf_we_w(rf_we_w), .halt_req(halt_req),
        .alu_src0_sel(alu_src0_sel), .alu_src1_sel(alu_src1_sel),
        .fetch_en(fetch_en), .decode_en(decode_en),
        .decode_clr(decode_clr), .execute_en(execute_en),
        .execute_clr(execute_clr), .memory_en(memory_en),
        .halt_ack(halt_ack), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.ADDR_W(5), .ALU_SRC_SEL_W(2), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset),
        .rf_src0_d(rf_src0_d), .rf_src1_d(rf_src1_d),
        .rf_src0_e(rf_src0_e), .rf_src1_e(rf_src1_e),
        .rf_dst_e(rf_dst_e), .mem2rf_e(mem2rf_e),
        .rf_waddr_m(rf_waddr_m), .rf_we_m(rf_we_m),
        .pc_src_m(pc_src_m), .dmem_req_m(dmem_req_m),
        .dmem_ready(dmem_ready), .rf_waddr_w(rf_waddr_w),
        .rf_we_w(rf_we_w), .halt_req(halt_req),
        .alu_src0_sel(s_sel0), .alu_src1_sel(s_sel1),
        .fetch_en(s_fe), .decode_en(s_de),
        .decode_clr(s_dc), .execute_en(s_ee),
        .execute_clr(s_ec), .memory_en(s_me),
        .halt_ack(s_ha), .stall_cnt(s_stall),
        .flush_cnt(s_flush)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] byp(input logic [4:0] s);
        if (rf_we_m && rf_waddr_m == s && s != 0) return 2'b10;
        if (rf_we_w && rf_waddr_w == s && s != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic longint sat(input longint c, input longint mx);
        return (c > mx) ? mx : c;
    endfunction

    task automatic model_reset();
        m_stalls  = 0;
        m_flushes = 0;
        m_halted  = 0;
        m_waiting = 0;
    endtask

    // Check the cycle's outputs against the model, then advance one clock.
    task automatic step();
        bit lu, wt;
        bit ef, ede, edc, eee, eec, eme;
        #1;
        lu = mem2rf_e && rf_dst_e != 0 &&
             (rf_dst_e == rf_src0_d || rf_dst_e == rf_src1_d);
        wt = dmem_req_m && !dmem_ready;
        {ef, ede, edc, eee, eec, eme} = 6'b110101;
        if (m_halted || wt) begin
            {ef, ede, edc, eee, eec, eme} = 6'b000000;
        end else if (pc_src_m) begin
            {ef, ede, edc, eee, eec, eme} = 6'b111111;
        end else if (lu) begin
            {ef, ede, edc, eee, eec, eme} = 6'b001101;
        end
        chk("sel0", 64'(alu_src0_sel), 64'(byp(rf_src0_e)));
        chk("sel1", 64'(alu_src1_sel), 64'(byp(rf_src1_e)));
        chk("en_clr", 64'({fetch_en, decode_en, decode_clr,
                           execute_en, execute_clr, memory_en}),
            64'({ef, ede, edc, eee, eec, eme}));
        chk("halt_ack", 64'(halt_ack), 64'(m_halted));
        chk("stall_cnt", 64'(stall_cnt), 64'(sat(m_stalls, 64'hFFFF_FFFF)));
        chk("flush_cnt", 64'(flush_cnt), 64'(sat(m_flushes, 64'hFFFF_FFFF)));
        chk("sat_stall", 64'(s_stall), 64'(sat(m_stalls, 15)));
        chk("sat_flush", 64'(s_flush), 64'(sat(m_flushes, 15)));
        if (!ef) m_stalls++;
        if (eec) m_flushes++;
        if (m_halted) begin
            m_halted = halt_req;
        end else if (m_waiting) begin
            m_waiting = wt;
        end else if (wt) begin
            m_waiting = 1;
        end else if (halt_req && !lu) begin
            m_halted = 1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic quiet();
        {rf_src0_d, rf_src1_d, rf_src0_e, rf_src1_e} = '0;
        {rf_dst_e, rf_waddr_m, rf_waddr_w} = '0;
        {mem2rf_e, rf_we_m, pc_src_m, dmem_req_m, rf_we_w} = '0;
        dmem_ready = 1'b1;
    endtask

    initial begin
        model_reset();
        quiet();
        #3;
        chk("rst_halt_ack", 64'(halt_ack), 64'(0));
        chk("rst_stall", 64'(stall_cnt), 64'(0));
        chk("rst_flush", 64'(flush_cnt), 64'(0));
        chk("rst_en", 64'({fetch_en, decode_en, execute_en, memory_en,
                           decode_clr, execute_clr}), 64'(6'b111100));
        @(negedge clk);
        reset = 1'b0;
        #1;

        // ME and WB both write x5; ME wins. Then x0 is never bypassed.
        rf_src0_e = 5; rf_we_m = 1; rf_waddr_m = 5; rf_we_w = 1; rf_waddr_w = 5;
        step();
        chk("byp_me", 64'(alu_src0_sel), 64'(2'b10));
        rf_src0_e = 0; rf_waddr_m = 0; rf_waddr_w = 0;
        step();
        chk("byp_x0", 64'(alu_src0_sel), 64'(2'b00));

        // Load-use on x7, then the load result is forwarded.
        quiet();
        mem2rf_e = 1; rf_dst_e = 7; rf_src0_d = 7;
        step();
        quiet();
        rf_src0_e = 7; rf_we_m = 1; rf_waddr_m = 7;
        step();
        chk("lu_stall", 64'(stall_cnt), 64'(1));

        // Branch flush together with load-use.
        quiet();
        mem2rf_e = 1; rf_dst_e = 3; rf_src1_d = 3; pc_src_m = 1;
        step();
        quiet();
        step();
        chk("br_flush", 64'(flush_cnt), 64'(1));
        chk("br_stall", 64'(stall_cnt), 64'(1));

        // Three wait-state cycles, then ready.
        quiet();
        dmem_req_m = 1; dmem_ready = 0;
        repeat (3) step();
        dmem_ready = 1;
        step();
        chk("wait_stall", 64'(stall_cnt), 64'(4));

        // Halt requested during a wait state: taken only after ready.
        dmem_ready = 0; halt_req = 1;
        repeat (2) step();
        dmem_ready = 1;
        step();
        chk("halt_deferred", 64'(halt_ack), 64'(0));
        dmem_req_m = 0;
        repeat (4) step();
        halt_req = 0;
        repeat (2) step();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            rf_src0_d  = 5'($urandom_range(0, 3));
            rf_src1_d  = 5'($urandom_range(0, 3));
            rf_src0_e  = 5'($urandom_range(0, 3));
            rf_src1_e  = 5'($urandom_range(0, 3));
            rf_dst_e   = 5'($urandom_range(0, 3));
            rf_waddr_m = 5'($urandom_range(0, 3));
            rf_waddr_w = 5'($urandom_range(0, 3));
            mem2rf_e   = ($urandom_range(0, 99) < 40);
            rf_we_m    = ($urandom_range(0, 99) < 70);
            rf_we_w    = ($urandom_range(0, 99) < 70);
            pc_src_m   = ($urandom_range(0, 99) < 12);
            dmem_req_m = ($urandom_range(0, 99) < 30);
            dmem_ready = ($urandom_range(0, 99) < 50);
            if ($urandom_range(0, 99) < 6) halt_req = !halt_req;
            step();
        end

        // Asynchronous reset in the middle of HALT.
        quiet();
        halt_req = 1;
        repeat (3) step();
        chk("in_halt", 64'(halt_ack), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_halt_ack", 64'(halt_ack), 64'(0));
        chk("arst_en", 64'({fetch_en, decode_en, execute_en, memory_en}),
            64'(4'b1111));
        chk("arst_stall", 64'(stall_cnt), 64'(0));
        chk("arst_sat", 64'(s_stall), 64'(0));
        model_reset();
        halt_req = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
